// File: rtl/div64_pkg.sv
// Shared types and constants for the 64/64 sequential divider.
package div64_pkg;

   localparam int WIDTH = 64;
   localparam int CNT_W = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [WIDTH-1:0] DIVZERO_QUOT = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] SIGNED_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

endpackage

// File: rtl/div64_sign_cond.sv
// Conditional two's-complement negate; yields |x| when i_neg flags a negative operand.
module div64_sign_cond #(
   parameter int WIDTH = div64_pkg::WIDTH
) (
   input  logic [WIDTH-1:0] i_val,
   input  logic             i_neg,
   output logic [WIDTH-1:0] o_val
);

   assign o_val = i_neg ? (~i_val + {{(WIDTH-1){1'b0}}, 1'b1}) : i_val;

endmodule

// File: rtl/div64x64_seq.sv
// Iterative radix-2 non-restoring 64/64 divider with per-operand signedness.
// Optional macro DIV64_FLUSH_EN adds a synchronous i_flush abort input.
module div64x64_seq #(
   parameter int WIDTH = div64_pkg::WIDTH,
   parameter int CNT_W = div64_pkg::CNT_W
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic             i_diva_ns,
   input  logic             i_divb_ns,
   input  logic [WIDTH-1:0] i_diva,
   input  logic [WIDTH-1:0] i_divb,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_quot,
   output logic [WIDTH-1:0] o_rem,
   output logic             o_dz
`ifdef DIV64_FLUSH_EN
   ,
   input  logic             i_flush
`endif
);

   import div64_pkg::*;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH:0]     r_p;
   logic [WIDTH-1:0]   r_q;
   logic [WIDTH-1:0]   r_d;
   logic               r_qneg;
   logic               r_rneg;
   logic [WIDTH-1:0]   r_quot;
   logic [WIDTH-1:0]   r_rem;
   logic               r_dz;

   logic               w_flush;
   logic               w_accept;
   logic               w_a_neg;
   logic               w_b_neg;
   logic               w_divzero;
   logic               w_ovf;
   logic [WIDTH-1:0]   w_amag;
   logic [WIDTH-1:0]   w_bmag;
   logic [WIDTH:0]     w_shift;
   logic [WIDTH:0]     w_p_nxt;
   logic [WIDTH-1:0]   w_q_nxt;
   logic [WIDTH-1:0]   w_rem_mag;
   logic [WIDTH-1:0]   w_quot_fix;
   logic [WIDTH-1:0]   w_rem_fix;
   logic               w_last;

`ifdef DIV64_FLUSH_EN
   assign w_flush = i_flush;
`else
   assign w_flush = 1'b0;
`endif

   assign w_accept  = i_valid & (r_state == IDLE) & ~w_flush;
   assign w_a_neg   = i_diva_ns & i_diva[WIDTH-1];
   assign w_b_neg   = i_divb_ns & i_divb[WIDTH-1];
   assign w_divzero = (i_divb == '0);
   assign w_ovf     = i_diva_ns & i_divb_ns & (i_diva == SIGNED_MIN) & (i_divb == DIVZERO_QUOT);
   assign w_last    = (r_cnt == CNT_W'(WIDTH-1));

   div64_sign_cond #(.WIDTH(WIDTH)) u_abs_a (
      .i_val (i_diva),
      .i_neg (w_a_neg),
      .o_val (w_amag)
   );

   div64_sign_cond #(.WIDTH(WIDTH)) u_abs_b (
      .i_val (i_divb),
      .i_neg (w_b_neg),
      .o_val (w_bmag)
   );

   // One non-restoring step: shift in the next dividend bit, then add or subtract by remainder sign.
   assign w_shift = {r_p[WIDTH-1:0], r_q[WIDTH-1]};
   assign w_p_nxt = r_p[WIDTH] ? (w_shift + {1'b0, r_d}) : (w_shift - {1'b0, r_d});
   assign w_q_nxt = {r_q[WIDTH-2:0], ~w_p_nxt[WIDTH]};

   assign w_rem_mag = r_p[WIDTH] ? (r_p[WIDTH-1:0] + r_d) : r_p[WIDTH-1:0];

   div64_sign_cond #(.WIDTH(WIDTH)) u_fix_q (
      .i_val (r_q),
      .i_neg (r_qneg),
      .o_val (w_quot_fix)
   );

   div64_sign_cond #(.WIDTH(WIDTH)) u_fix_r (
      .i_val (w_rem_mag),
      .i_neg (r_rneg),
      .o_val (w_rem_fix)
   );

   always_comb begin
      w_state_nxt = r_state;
      o_ready     = 1'b0;
      o_valid     = 1'b0;
      case (r_state)
         IDLE: begin
            o_ready = 1'b1;
            if (w_accept) begin
               w_state_nxt = (w_divzero | w_ovf) ? DONE : CALC;
            end
         end
         CALC: begin
            if (w_last) begin
               w_state_nxt = FIX;
            end
         end
         FIX: begin
            w_state_nxt = DONE;
         end
         DONE: begin
            o_valid = 1'b1;
            if (i_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
      if (w_flush) begin
         w_state_nxt = IDLE;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_quot  <= '0;
         r_rem   <= '0;
         r_dz    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_cnt <= '0;
            if (w_divzero) begin
               r_quot <= DIVZERO_QUOT;
               r_rem  <= i_diva;
               r_dz   <= 1'b1;
            end else if (w_ovf) begin
               r_quot <= i_diva;
               r_rem  <= '0;
               r_dz   <= 1'b0;
            end
         end else if ((r_state == CALC) && !w_flush) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if ((r_state == FIX) && !w_flush) begin
            r_quot <= w_quot_fix;
            r_rem  <= w_rem_fix;
            r_dz   <= 1'b0;
         end
      end
   end

   // Iteration datapath carries no reset; it is always reloaded on accept.
   always_ff @(posedge i_clk) begin
      if (w_accept) begin
         r_p    <= '0;
         r_q    <= w_amag;
         r_d    <= w_bmag;
         r_qneg <= w_a_neg ^ w_b_neg;
         r_rneg <= w_a_neg;
      end else if (r_state == CALC) begin
         r_p <= w_p_nxt;
         r_q <= w_q_nxt;
      end
   end

   assign o_quot = r_quot;
   assign o_rem  = r_rem;
   assign o_dz   = r_dz;

endmodule
